// File: rtl/fios_dsp_pkg.sv
// Shared constants and types for the FIOS DSP column sequencer.
package fios_dsp_pkg;

    // Result word width produced per column
    localparam int unsigned WORD_W = 17;

    // DSP OPMODE encodings {Z[2:0], Y[1:0], X[1:0]}
    localparam logic [6:0] OPM_ZERO    = 7'b0000000; // P = 0
    localparam logic [6:0] OPM_M       = 7'b0000101; // P = M
    localparam logic [6:0] OPM_M_ACC   = 7'b0100101; // P = P + M
    localparam logic [6:0] OPM_M_SHACC = 7'b1100101; // P = (P>>17) + M
    localparam logic [6:0] OPM_SH      = 7'b1100000; // P = P>>17

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FLUSH,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/fios_dsp_seq_if.sv
// Sequencer bus: start handshake, operand indices, DSP control and result flags.
interface fios_dsp_seq_if
    import fios_dsp_pkg::*;
#(
    parameter int unsigned IDX_W = 5
);
    logic             start_i;
    logic [IDX_W:0]   n_words_i;
    logic             busy_o;
    logic [IDX_W-1:0] a_idx_o;
    logic [IDX_W-1:0] b_idx_o;
    logic             idx_valid_o;
    logic [6:0]       OPMODE_o;
    logic             CREG_en_o;
    logic             res_valid_o;
    logic [IDX_W:0]   res_idx_o;
    logic             done_o;

    // Sequencer side
    modport master (
        input  start_i, n_words_i,
        output busy_o, a_idx_o, b_idx_o, idx_valid_o, OPMODE_o,
               CREG_en_o, res_valid_o, res_idx_o, done_o
    );

    // Controller / consumer side
    modport slave (
        output start_i, n_words_i,
        input  busy_o, a_idx_o, b_idx_o, idx_valid_o, OPMODE_o,
               CREG_en_o, res_valid_o, res_idx_o, done_o
    );
endinterface

// File: rtl/fios_dsp_delay.sv
// Parameterised shift register with synchronous clear; DEPTH 0 is a wire.
module fios_dsp_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            // Shift one stage per clock; reset flushes every stage
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int unsigned n = 0; n < DEPTH; n++) begin
                        r_pipe[n] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_d;
                    for (int unsigned n = 1; n < DEPTH; n++) begin
                        r_pipe[n] <= r_pipe[n-1];
                    end
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/fios_dsp_seq.sv
// Product-scanning column scheduler for one DSP slice: issues operand word
// indices column by column and aligns OPMODE / result flags to the pipeline.
module fios_dsp_seq
    import fios_dsp_pkg::*;
#(
    parameter int unsigned S_MAX  = 32,
    parameter int unsigned ABREG  = 1,
    parameter int unsigned MREG   = 1,
    parameter int unsigned OP_LAT = 1,
    parameter int unsigned IDX_W  = $clog2(S_MAX)
) (
    input logic            clock_i,
    input logic            reset_i,
    fios_dsp_seq_if.master bus
);
    localparam int unsigned CW = IDX_W + 1;
    // Index-to-OPMODE alignment and index-to-P_o result latency
    localparam int unsigned D  = OP_LAT + ABREG + MREG - 1;
    localparam int unsigned L  = OP_LAT + ABREG + MREG + 1;
    localparam int unsigned RW = CW + 2;

    seq_state_t       r_state, w_state_nxt;
    logic [CW-1:0]    r_s, w_s_nxt;       // operand word count S
    logic [CW-1:0]    r_k, w_k_nxt;       // current column
    logic [IDX_W-1:0] r_i, w_i_nxt;       // current A index within column

    logic [CW-1:0]    w_lo, w_hi, w_k_inc, w_k_last;
    logic [IDX_W-1:0] w_lo_inc, w_j;
    logic             w_col_first, w_col_last, w_n_ok;

    logic             w_issue, w_res_valid, w_done;
    logic [6:0]       w_opm, w_opm_d;
    logic [CW-1:0]    w_res_idx;
    logic [RW-1:0]    w_res_d;
    logic             w_res_valid_d, w_done_d;
    logic [CW-1:0]    w_res_idx_d;

    // Column bounds: i runs max(0,k-S+1)..min(k,S-1), j = k-i
    always_comb begin
        w_lo        = (r_k >= r_s) ? (r_k - r_s + CW'(1)) : '0;
        w_hi        = (r_k < r_s) ? r_k : (r_s - CW'(1));
        w_k_inc     = r_k + CW'(1);
        w_lo_inc    = (w_k_inc >= r_s) ? IDX_W'(w_k_inc - r_s + CW'(1)) : '0;
        // 2S-2 wraps correctly in CW bits even when 2S overflows
        w_k_last    = r_s + r_s - CW'(2);
        w_j         = r_k[IDX_W-1:0] - r_i;
        w_col_first = ({1'b0, r_i} == w_lo);
        w_col_last  = ({1'b0, r_i} == w_hi);
        w_n_ok      = (bus.n_words_i != '0) && (bus.n_words_i <= CW'(S_MAX));
    end

    // State and scan counters
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_k     <= '0;
            r_i     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_k     <= w_k_nxt;
            r_i     <= w_i_nxt;
        end
    end

    // Next state, scan advance and undelayed OPMODE / result tags
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_k_nxt     = r_k;
        w_i_nxt     = r_i;
        w_issue     = 1'b0;
        w_opm       = OPM_ZERO;
        w_res_valid = 1'b0;
        w_res_idx   = '0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start_i && w_n_ok) begin
                    w_state_nxt = ST_ISSUE;
                    w_s_nxt     = bus.n_words_i;
                    w_k_nxt     = '0;
                    w_i_nxt     = '0;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (r_k == '0) begin
                    w_opm = OPM_M;
                end else if (w_col_first) begin
                    w_opm = OPM_M_SHACC;
                end else begin
                    w_opm = OPM_M_ACC;
                end
                if (w_col_last) begin
                    w_res_valid = 1'b1;
                    w_res_idx   = r_k;
                    if (r_k == w_k_last) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_k_nxt = w_k_inc;
                        w_i_nxt = w_lo_inc;
                    end
                end else begin
                    w_i_nxt = r_i + IDX_W'(1);
                end
            end
            ST_FLUSH: begin
                w_opm       = OPM_SH;
                w_res_valid = 1'b1;
                w_res_idx   = w_k_last + CW'(1);
                w_done      = 1'b1;
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_done_d) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    fios_dsp_delay #(
        .WIDTH (7),
        .DEPTH (D)
    ) u_opm_dly (
        .i_clk (clock_i),
        .i_rst (reset_i),
        .i_d   (w_opm),
        .o_q   (w_opm_d)
    );

    fios_dsp_delay #(
        .WIDTH (RW),
        .DEPTH (L)
    ) u_res_dly (
        .i_clk (clock_i),
        .i_rst (reset_i),
        .i_d   ({w_done, w_res_idx, w_res_valid}),
        .o_q   (w_res_d)
    );

    assign {w_done_d, w_res_idx_d, w_res_valid_d} = w_res_d;

    // Outputs are forced to their idle values while reset is held
    assign bus.busy_o      = (r_state != ST_IDLE) && !reset_i;
    assign bus.idx_valid_o = w_issue && !reset_i;
    assign bus.a_idx_o     = (w_issue && !reset_i) ? r_i : '0;
    assign bus.b_idx_o     = (w_issue && !reset_i) ? w_j : '0;
    assign bus.OPMODE_o    = reset_i ? OPM_ZERO : w_opm_d;
    assign bus.CREG_en_o   = 1'b0;
    assign bus.res_valid_o = w_res_valid_d && !reset_i;
    assign bus.res_idx_o   = reset_i ? '0 : w_res_idx_d;
    assign bus.done_o      = w_done_d && !reset_i;

endmodule

// File: doc/fios_dsp_seq.md
# fios_dsp_seq

Product-scanning sequencer for one `generic_DSP_NOCASC_3A` slice. It computes an S-word × S-word product (17-bit words) on the slice.
- It emits operand word indices to the operand memories and drives the DSP `OPMODE` with pipeline-aligned timing.
- It flags each 17-bit result word as it appears on `P_o[16:0]`.
- It is the column scheduler underneath the FIOS Montgomery datapath.

## Interface
Parameters:
- `S_MAX`, 32, largest supported operand word count
- `ABREG`, 1, must match the DSP `ABREG`
- `MREG`, 1, must match the DSP `MREG`
- `OP_LAT`, 1, operand memory read latency (index → `A_i`/`B_i`)
- `IDX_W`, `$clog2(S_MAX)`, operand index width

Ports:
- `clock_i` in 1 — single clock
- `reset_i` in 1 — synchronous, active-high reset
- `start_i` in 1 — start request, sampled only in IDLE
- `n_words_i` in IDX_W+1 — S, sampled with `start_i`; legal range 1..S_MAX
- `busy_o` out 1 — operation in progress
- `a_idx_o` out IDX_W — A word index i
- `b_idx_o` out IDX_W — B word index j
- `idx_valid_o` out 1 — indices valid this cycle
- `OPMODE_o` out 7 — to DSP `OPMODE_i`, already delay-aligned
- `CREG_en_o` out 1 — to DSP `CREG_en_i`; constant 0
- `res_valid_o` out 1 — `P_o[16:0]` of the DSP holds result word `res_idx_o`
- `res_idx_o` out IDX_W+1 — result word index, 0..2S-1
- `done_o` out 1 — one-cycle pulse with the final result word

## Operation
- FSM states: IDLE, ISSUE, FLUSH, DRAIN.
- **IDLE → ISSUE:** on `start_i` with 1 ≤ `n_words_i` ≤ S_MAX. Otherwise the request is ignored and `busy_o` stays 0.
- **ISSUE:** one product per cycle, S² cycles total.
  - Columns run k = 0..2S-2.
  - Within column k, i runs from max(0, k-S+1) up to min(k, S-1), with j = k-i.
- **OPMODE per issued product:**
  - First product overall: `7'b0000101` (P = M).
  - First product of column k > 0: `7'b1100101` (P = (P>>17) + M).
  - Any other product: `7'b0100101` (P = P + M).
- **ISSUE → FLUSH:** after the last product. FLUSH lasts 1 cycle, `idx_valid_o` = 0, OPMODE `7'b1100000` (P = P>>17).
- **FLUSH → DRAIN:** DRAIN waits until the final result is flagged, then returns to IDLE.
- **Idle OPMODE:** `7'b0000000`.
- **Result flagging:**
  - Column k's sum is flagged as word k, with `res_idx_o` = k, on the last product of that column.
  - FLUSH is flagged as word 2S-1.
  - Each result is visible on `P_o` for exactly one cycle, and the consumer captures it on `res_valid_o`.
- **Width rule:** carries propagate inside the 48-bit P, with no truncation between columns. This is valid for S ≤ 2^13.
- `start_i` is ignored while `busy_o` = 1.
- `reset_i` in any state:
  - Next cycle is IDLE.
  - All delay lines are cleared.
  - No `res_valid_o` or `done_o` is emitted for the aborted operation.

## Timing
- Output values during and after reset: `busy_o`, `idx_valid_o`, `res_valid_o`, `done_o`, `CREG_en_o` = 0; `OPMODE_o` = 0; all indices = 0.
- `start_i` sampled at edge of cycle 0 → first issue in cycle 1; `busy_o` = 1 from cycle 1 through the `done_o` cycle inclusive.
- `OPMODE_o` lags the matching index by D = OP_LAT+ABREG+MREG-1 cycles (2 with defaults).
- `res_valid_o` lags the issue of the column's last product by L = OP_LAT+ABREG+MREG+1 cycles (4 with defaults). The flush result follows the same L offset from the FLUSH cycle.
- Total cycles from start to `done_o` = S² + 1 + L.
- Back-to-back: a new `start_i` is accepted in the cycle after `done_o`.

## Structure
- Package `fios_dsp_pkg`:
  - OPMODE constants `OPM_ZERO`, `OPM_M`, `OPM_M_ACC`, `OPM_M_SHACC`, `OPM_SH`.
  - State enum `seq_state_t`.
  - The 17-bit word width constant.
- Sub-module `fios_dsp_delay`: a parameterised shift register (width, depth ≥ 0, synchronous clear). It is instantiated for OPMODE (depth D) and for {valid, idx, done} (depth L).

## Test plan
- **S = 1, A = 0x1FFFF, B = 0x1FFFF, DSP model attached** → word0 = 0x00001 at cycle 5, word1 = 0x1FFFE at cycle 6 with `done_o`; `busy_o` spans cycles 1–6.
- **S = 2, A = {0x1FFFF, 0x1FFFF}, B = same** → index order (0,0), (0,1), (1,0), (1,1). OPMODE sequence 0000101, 1100101, 0100101, 1100101, 1100000. Four result words equal (2^34-1)², LSW first.
- **S = S_MAX, random operands** → 2·S_MAX words match a reference product; `done_o` at cycle S_MAX² + 1 + 4.
- **`n_words_i` = 0 and S_MAX+1 with `start_i`** → no busy, no `idx_valid_o`, `OPMODE_o` stays 0.
- **`start_i` pulsed mid-operation** → ignored, results unchanged. **`reset_i` asserted in ISSUE** → IDLE next cycle, all outputs at reset values, no stray `res_valid_o` in the following L cycles.
- **Back-to-back starts with S = 3 then S = 1** → second start accepted the cycle after the first `done_o`; both result streams are correct.
